// File: rtl/sram_dp_be.sv
// ---------------------------------------------------------------------------
// sram_dp_be
// Simple dual-port SRAM (one write port, one read port, single clock) intended
// for cache tag/data arrays.
//   * per-byte write enables on the write port
//   * registered read pipeline of 1 or 2 cycles (RD_LAT)
//   * selectable same-address read-during-write result (RDW_MODE)
//   * optional post-reset clear sequencer that zeroes every entry before the
//     array accepts traffic (CLEAR_ON_RST)
//
// Ports
//   clk      in   1          clock, all state updates on the rising edge
//   rst_n    in   1          asynchronous active-low reset
//   we       in   1          write request
//   wbe      in   WIDTH/8    byte enables, bit i selects d_write[8i+7:8i]
//   waddr    in   ASIZE      write address
//   d_write  in   WIDTH      write data
//   re       in   1          read request
//   raddr    in   ASIZE      read address
//   d_read   out  WIDTH      read data, meaningful when rvalid=1, else holds
//   rvalid   out  1          one-cycle pulse per accepted read
//   busy     out  1          high while the clear sequence runs
// ---------------------------------------------------------------------------
module sram_dp_be #(
    parameter int WIDTH        = 64,
    parameter int ASIZE        = 4,
    parameter int RD_LAT       = 1,
    parameter int RDW_MODE     = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [WIDTH/8-1:0]   wbe,
    input  logic [ASIZE-1:0]     waddr,
    input  logic [WIDTH-1:0]     d_write,
    input  logic                 re,
    input  logic [ASIZE-1:0]     raddr,
    output logic [WIDTH-1:0]     d_read,
    output logic                 rvalid,
    output logic                 busy
);

    localparam int NBYTE = WIDTH / 8;
    localparam int DEPTH = 1 << ASIZE;

    localparam logic [ASIZE-1:0] LAST_ADDR = ASIZE'(DEPTH - 1);
    localparam logic [ASIZE-1:0] ADDR_ONE  = ASIZE'(1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;

    // Replace the bytes of old_w selected by be with the matching bytes of new_w.
    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [NBYTE-1:0] be
    );
        logic [WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NBYTE; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [ASIZE-1:0]   r_clr_addr;
    logic [ASIZE-1:0]   w_clr_addr_nxt;
    logic               w_ready;

    logic               w_wr_en;
    logic [ASIZE-1:0]   w_wr_addr;
    logic [WIDTH-1:0]   w_wr_data;
    logic [NBYTE-1:0]   w_wr_be;
    logic [WIDTH-1:0]   w_wr_merged;

    logic               w_rd_en;
    logic               w_rd_hit;
    logic [WIDTH-1:0]   w_rd_old;
    logic [WIDTH-1:0]   w_rd_word;

    logic               w_pipe_valid;
    logic [WIDTH-1:0]   w_pipe_data;

    logic [WIDTH-1:0]   r_d_read;
    logic               r_rvalid;

    // Storage has no reset; the clear sequencer is what defines its contents.
    logic [WIDTH-1:0]   r_mem [DEPTH];

    // -----------------------------------------------------------------------
    // Clear / ready FSM
    // -----------------------------------------------------------------------

    // State and clear-address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RST_STATE;
            r_clr_addr <= {ASIZE{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    // Next-state logic: walk every address once, then park in READY for good.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            ST_CLEAR: begin
                w_clr_addr_nxt = r_clr_addr + ADDR_ONE;
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_READY: begin
                w_state_nxt    = ST_READY;
                w_clr_addr_nxt = {ASIZE{1'b0}};
            end
            default: begin
                w_state_nxt    = RST_STATE;
                w_clr_addr_nxt = {ASIZE{1'b0}};
            end
        endcase
    end

    assign w_ready = (r_state == ST_READY);

    // -----------------------------------------------------------------------
    // Write port
    // -----------------------------------------------------------------------

    // Write-port mux: the clear sequencer owns the port until READY.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = {ASIZE{1'b0}};
        w_wr_data = {WIDTH{1'b0}};
        w_wr_be   = {NBYTE{1'b0}};
        if (!w_ready) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_clr_addr;
            w_wr_data = {WIDTH{1'b0}};
            w_wr_be   = {NBYTE{1'b1}};
        end else begin
            // All-zero byte enables make the write a no-op.
            w_wr_en   = we && (|wbe);
            w_wr_addr = waddr;
            w_wr_data = d_write;
            w_wr_be   = wbe;
        end
    end

    assign w_wr_merged = merge_bytes(r_mem[w_wr_addr], w_wr_data, w_wr_be);

    // Memory array update.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_merged;
        end
    end

    // -----------------------------------------------------------------------
    // Read port
    // -----------------------------------------------------------------------
    assign w_rd_en  = w_ready && re;
    assign w_rd_old = r_mem[raddr];
    assign w_rd_hit = w_ready && w_wr_en && (waddr == raddr);

    // Same-edge collision: either the pre-write word or the merged word.
    always_comb begin
        w_rd_word = w_rd_old;
        if ((RDW_MODE != 0) && w_rd_hit) begin
            w_rd_word = merge_bytes(w_rd_old, d_write, wbe);
        end else begin
            w_rd_word = w_rd_old;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic               r_s1_valid;
            logic [WIDTH-1:0]   r_s1_data;

            // First read stage; reset drops any read in flight.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_valid <= 1'b0;
                    r_s1_data  <= {WIDTH{1'b0}};
                end else begin
                    r_s1_valid <= w_rd_en;
                    if (w_rd_en) begin
                        r_s1_data <= w_rd_word;
                    end
                end
            end

            assign w_pipe_valid = r_s1_valid;
            assign w_pipe_data  = r_s1_data;
        end else begin : g_lat1
            assign w_pipe_valid = w_rd_en;
            assign w_pipe_data  = w_rd_word;
        end
    endgenerate

    // Output stage; data only moves on a valid read so it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_d_read <= {WIDTH{1'b0}};
        end else begin
            r_rvalid <= w_pipe_valid;
            if (w_pipe_valid) begin
                r_d_read <= w_pipe_data;
            end
        end
    end

    assign d_read = r_d_read;
    assign rvalid = r_rvalid;
    assign busy   = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_sram_dp_be.sv
// ---------------------------------------------------------------------------
// tb_sram_dp_be
// Two instances share clock, reset and stimulus:
//   u_dut_a : RD_LAT=1, RDW_MODE=0 (old data on collision)
//   u_dut_b : RD_LAT=2, RDW_MODE=1 (merged data on collision)
// A word-level memory model predicts busy / rvalid / d_read for both.
// ---------------------------------------------------------------------------
module tb_sram_dp_be;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [7:0]  wbe;
    logic [3:0]  waddr;
    logic [63:0] d_write;
    logic        re;
    logic [3:0]  raddr;
    logic [63:0] d_read_a, d_read_b;
    logic        rvalid_a, rvalid_b;
    logic        busy_a, busy_b;

    sram_dp_be #(.WIDTH(64), .ASIZE(4), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RST(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .wbe(wbe), .waddr(waddr), .d_write(d_write),
        .re(re), .raddr(raddr), .d_read(d_read_a), .rvalid(rvalid_a), .busy(busy_a)
    );

    sram_dp_be #(.WIDTH(64), .ASIZE(4), .RD_LAT(2), .RDW_MODE(1), .CLEAR_ON_RST(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .wbe(wbe), .waddr(waddr), .d_write(d_write),
        .re(re), .raddr(raddr), .d_read(d_read_b), .rvalid(rvalid_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [63:0] m_mem [DEPTH];
    int          m_clr;          // clear writes still to go
    logic        m_av, m_bv, m_pv;
    logic [63:0] m_ad, m_bd, m_pd;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_clr = DEPTH;
        m_av = 1'b0; m_ad = 64'h0;
        m_bv = 1'b0; m_bd = 64'h0;
        m_pv = 1'b0; m_pd = 64'h0;
    endtask

    // One clock edge of the specified behaviour, using the current inputs.
    task automatic model_edge();
        logic [63:0] old_w, new_w;
        if (!rst_n) begin
            model_reset();
        end else if (m_clr > 0) begin
            m_mem[DEPTH - m_clr] = 64'h0;
            m_clr--;
            m_av = 1'b0;
            m_bv = 1'b0;
            m_pv = 1'b0;
        end else begin
            old_w = m_mem[raddr];
            if (we) begin
                for (int i = 0; i < 8; i++) begin
                    if (wbe[i]) m_mem[waddr][8*i +: 8] = d_write[8*i +: 8];
                end
            end
            new_w = m_mem[raddr];
            m_av = re;
            if (re) m_ad = old_w;
            m_bv = m_pv;
            if (m_pv) m_bd = m_pd;
            m_pv = re;
            m_pd = new_w;
        end
    endtask

    task automatic check_all();
        chk("busy_a",   64'(busy_a),   64'(m_clr > 0));
        chk("busy_b",   64'(busy_b),   64'(m_clr > 0));
        chk("rvalid_a", 64'(rvalid_a), 64'(m_av));
        chk("rvalid_b", 64'(rvalid_b), 64'(m_bv));
        chk("d_read_a", d_read_a, m_ad);
        chk("d_read_b", d_read_b, m_bd);
    endtask

    task automatic step(input logic s_we, input logic [7:0] s_wbe, input logic [3:0] s_wa,
                        input logic [63:0] s_d, input logic s_re, input logic [3:0] s_ra);
        we = s_we; wbe = s_wbe; waddr = s_wa; d_write = s_d; re = s_re; raddr = s_ra;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 4'h0, 64'h0, 1'b0, 4'h0);
    endtask

    task automatic rnd_step(input int amax);
        step(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, amax)),
             {$urandom, $urandom}, 1'($urandom_range(0, 1)), 4'($urandom_range(0, amax)));
    endtask

    // Count edges taken while busy is high; bounded.
    task automatic count_busy(input logic traffic, output int n);
        n = 0;
        while (busy_a && n < 40) begin
            if (traffic) rnd_step(15);
            else idle();
            n++;
        end
    endtask

    task automatic read_all_zero(input string nm);
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, 8'h00, 4'h0, 64'h0, 1'b1, 4'(a));
            chk({nm, "_rvalid"}, 64'(rvalid_a), 64'h1);
            chk({nm, "_zero"}, d_read_a, 64'h0);
        end
        idle();
        idle();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [7:0]  wbe;
        logic [3:0]  waddr;
        logic [63:0] wd;
        logic        re;
        logic [3:0]  raddr;
        logic        eav;
        logic [63:0] ead;
        logic        ebv;
        logic [63:0] ebd;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [7:0] be, input logic [3:0] wa,
                                input logic [63:0] wd, input logic r, input logic [3:0] ra,
                                input logic eav, input logic [63:0] ead,
                                input logic ebv, input logic [63:0] ebd);
        vec_t v;
        v.we = w; v.wbe = be; v.waddr = wa; v.wd = wd; v.re = r; v.raddr = ra;
        v.eav = eav; v.ead = ead; v.ebv = ebv; v.ebd = ebd;
        return v;
    endfunction

    localparam logic [63:0] K3  = 64'h1122334455667788;
    localparam logic [63:0] K3M = 64'h11223344FFFFFFFF;
    localparam logic [63:0] K1S = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] A0  = 64'h0123456789ABCDEF;
    localparam logic [63:0] A1  = 64'hFEDCBA9876543210;
    localparam logic [63:0] A2  = 64'hA5A5A5A55A5A5A5A;

    vec_t vt[17];
    int   nb;

    initial begin
        //           we    wbe    wa    wd     re    ra    a_v   a_d    b_v   b_d
        vt[0]  = mk(1'b1, 8'hFF, 4'd3, K3,    1'b0, 4'd0, 1'b0, 64'h0, 1'b0, 64'h0);
        vt[1]  = mk(1'b0, 8'h00, 4'd0, 64'h0, 1'b1, 4'd3, 1'b1, K3,    1'b0, 64'h0);
        vt[2]  = mk(1'b1, 8'h0F, 4'd3, K1S,   1'b0, 4'd0, 1'b0, K3,    1'b1, K3);
        vt[3]  = mk(1'b0, 8'h00, 4'd0, 64'h0, 1'b1, 4'd3, 1'b1, K3M,   1'b0, K3);
        vt[4]  = mk(1'b1, 8'hFF, 4'd5, K1S,   1'b1, 4'd5, 1'b1, 64'h0, 1'b1, K3M);
        vt[5]  = mk(1'b1, 8'hFF, 4'd0, A0,    1'b0, 4'd0, 1'b0, 64'h0, 1'b1, K1S);
        vt[6]  = mk(1'b1, 8'hFF, 4'd1, A1,    1'b0, 4'd0, 1'b0, 64'h0, 1'b0, K1S);
        vt[7]  = mk(1'b1, 8'hFF, 4'd2, A2,    1'b0, 4'd0, 1'b0, 64'h0, 1'b0, K1S);
        vt[8]  = mk(1'b0, 8'h00, 4'd0, 64'h0, 1'b1, 4'd0, 1'b1, A0,    1'b0, K1S);
        vt[9]  = mk(1'b0, 8'h00, 4'd0, 64'h0, 1'b1, 4'd1, 1'b1, A1,    1'b1, A0);
        vt[10] = mk(1'b0, 8'h00, 4'd0, 64'h0, 1'b1, 4'd2, 1'b1, A2,    1'b1, A1);
        vt[11] = mk(1'b0, 8'h00, 4'd0, 64'h0, 1'b1, 4'd3, 1'b1, K3M,   1'b1, A2);
        vt[12] = mk(1'b0, 8'h00, 4'd0, 64'h0, 1'b0, 4'd0, 1'b0, K3M,   1'b1, K3M);
        vt[13] = mk(1'b0, 8'h00, 4'd0, 64'h0, 1'b0, 4'd0, 1'b0, K3M,   1'b0, K3M);
        vt[14] = mk(1'b1, 8'h00, 4'd3, 64'h0, 1'b0, 4'd0, 1'b0, K3M,   1'b0, K3M);
        vt[15] = mk(1'b0, 8'h00, 4'd0, 64'h0, 1'b1, 4'd3, 1'b1, K3M,   1'b0, K3M);
        vt[16] = mk(1'b0, 8'h00, 4'd0, 64'h0, 1'b0, 4'd0, 1'b0, K3M,   1'b1, K3M);

        for (int i = 0; i < DEPTH; i++) m_mem[i] = 64'h0;
        we = 1'b0; wbe = 8'h00; waddr = 4'h0; d_write = 64'h0; re = 1'b0; raddr = 4'h0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        idle();
        idle();

        // Clear after power-up: busy for exactly DEPTH edges, then all zero.
        rst_n = 1'b1;
        count_busy(1'b0, nb);
        chk("t1_busy_cycles", 64'(nb), 64'd16);
        read_all_zero("t1");

        // Directed byte-enable, collision and pipelined-read vectors.
        for (int k = 0; k < 17; k++) begin
            step(vt[k].we, vt[k].wbe, vt[k].waddr, vt[k].wd, vt[k].re, vt[k].raddr);
            chk($sformatf("vec%0d_rvalid_a", k), 64'(rvalid_a), 64'(vt[k].eav));
            chk($sformatf("vec%0d_d_read_a", k), d_read_a, vt[k].ead);
            chk($sformatf("vec%0d_rvalid_b", k), 64'(rvalid_b), 64'(vt[k].ebv));
            chk($sformatf("vec%0d_d_read_b", k), d_read_b, vt[k].ebd);
        end

        // Randomised traffic; narrow address range first to force collisions.
        for (int k = 0; k < 300; k++) rnd_step(3);
        for (int k = 0; k < 200; k++) rnd_step(15);

        // Reset during an in-flight read drops it.
        step(1'b0, 8'h00, 4'h0, 64'h0, 1'b1, 4'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("inflight_rvalid_b", 64'(rvalid_b), 64'h0);
        check_all();
        idle();
        rst_n = 1'b1;

        // Reset again at clear cycle 7 while driving traffic.
        for (int k = 0; k < 7; k++) rnd_step(15);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        rnd_step(15);
        rst_n = 1'b1;
        count_busy(1'b1, nb);
        chk("t6_busy_cycles", 64'(nb), 64'd16);
        read_all_zero("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
